pc_sequencer: RTL
=================

# pc_sequencer

Parametrised next-PC sequencer for the single-cycle MIPS core, replacing the fixed PC register, the two PC adders and the chained PC-source muxes. It adds four branch conditions, `jal` link generation, `jr`, and pipeline stall. It also keeps a return-address stack (RAS) that checks each `jr` target against the most recent `jal` link. It sits between the control/ALU outputs and the instruction memory address.

## Interface
Parameters:
- ADDR_W, 32, PC width; legal range 28..64.
- RAS_DEPTH, 4, RAS entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset; word aligned.

Ports:
- clk_i  in  1  the only clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hold the PC and all state; every request is ignored.
- branch_i  in  1  the current instruction is a conditional branch.
- branch_type_i  in  2  branch condition: 0 beq (zero_i), 1 bne (!zero_i), 2 bltz (neg_i), 3 bgez (!neg_i).
- zero_i  in  1  ALU zero flag.
- neg_i  in  1  ALU result sign bit.
- imm_i  in  ADDR_W  sign-extended 16-bit word offset.
- jump_i  in  1  `j`.
- jal_i  in  1  `jal`; jumps like `j` and pushes the link onto the RAS.
- target26_i  in  26  instruction bits [25:0].
- jr_i  in  1  `jr`.
- jr_target_i  in  ADDR_W  rs register data.
- pc_o  out  ADDR_W  current PC (registered).
- pc_plus4_o  out  ADDR_W  pc_o + 4 (combinational).
- link_o  out  ADDR_W  pc_o + 4, the data to write to $31 on `jal`.
- redirect_o  out  1  registered; high for one cycle after a non-sequential PC load.
- ras_top_o  out  ADDR_W  current top-of-stack entry; 0 when the stack is empty.
- ras_count_o  out  $clog2(RAS_DEPTH)+1  number of valid entries.
- ras_hit_o  out  1  combinational; jr_i & !stall_i & count>0 & jr_target_i==top.
- jr_miss_cnt_o  out  8  saturating count of `jr` executions that did not hit.
- ras_ovf_o  out  1  sticky; set when a push occurs while the stack is full.
- ras_unf_o  out  1  sticky; set when a pop occurs while the stack is empty.

## Operation
- Next-PC selection, highest priority first:
  - stall_i: hold.
  - jr_i: {jr_target_i[ADDR_W-1:2], 2'b00}.
  - jump_i | jal_i: {pc_plus4_o[ADDR_W-1:28], target26_i, 2'b00}.
  - Branch taken (branch_i and the condition is true): pc_plus4_o + (imm_i << 2), truncated to ADDR_W.
  - Otherwise: pc_plus4_o.
- Arithmetic rules:
  - All additions wrap modulo 2^ADDR_W.
  - When ADDR_W == 28, the jump target is {target26_i, 2'b00}.
- RAS structure: a circular buffer with a top pointer and a saturating count. Updates are suppressed while stall_i is high.
  - Push (jal_i, with jr_i low): write link_o at top+1 and advance the top pointer. If count < DEPTH, count increments. If count == DEPTH, the oldest entry is overwritten, count stays at DEPTH, and ras_ovf_o is set.
  - Pop (jr_i, with jal_i low): if count > 0, retreat the top pointer and decrement count. If count == 0, nothing changes except that ras_unf_o is set.
  - jal_i and jr_i together: the `jr` has priority for the PC. On the RAS the pop is followed by the push, so the top entry is replaced by link_o and count is unchanged. If count was 0, count becomes 1 and ras_unf_o is set.
- jr_miss_cnt_o increments on each non-stalled jr_i with ras_hit_o low, and saturates at 255.
- Reset behaviour: pc_o=RESET_PC, redirect_o=0, count=0, pointer=0, jr_miss_cnt_o=0, ras_ovf_o=0, ras_unf_o=0. Stack contents are not cleared; they are not visible while count=0.

## Timing
- Latency is one cycle: the inputs sampled at edge N determine pc_o after edge N.
- redirect_o is high in the cycle after an edge that loaded a jr, jump, jal or taken-branch target. It is low after stall cycles and sequential cycles.
- pc_plus4_o, link_o, ras_top_o and ras_hit_o are combinational from registered state and current inputs.
- The RAS top is visible one cycle after the push.
- rst_i overrides stall_i and every other request in the same cycle.
- Reset asserted mid-sequence discards all pending state at the next edge.

## Test plan
- Reset then free-run: with RESET_PC=0x100 and no requests, pc_o = 0x100, 0x104, 0x108, and redirect_o stays 0.
- Branch conditions:
  - At pc 0x200 with imm=-2 and beq, zero_i=1: pc_o becomes 0x1FC and redirect_o=1 next cycle.
  - Repeat with bne and zero_i=1: pc_o becomes 0x204.
  - bltz with neg_i=1: taken; bgez with neg_i=1: not taken.
- Jump and link: at pc 0x1000_0040 with jal_i and target26=0x000_0010, pc_o becomes 0x1000_0040 and ras_top_o becomes 0x1000_0044. Then jr to 0x1000_0044 gives ras_hit_o=1, count back to 0 and jr_miss_cnt_o unchanged.
- Overflow and underflow: with DEPTH=4, five pushes give count=4, ras_ovf_o=1 and the oldest link lost. Four pops return the four newest links in LIFO order. A fifth pop sets ras_unf_o=1 and leaves count=0.
- Stall and simultaneous requests: stall_i held with jr_i, jal_i and branch_i all asserted leaves pc_o, count and flags frozen. After release, jal_i+jr_i together loads the jr target and replaces the RAS top, with count unchanged.
- Miss counter and reset: 300 jr executions to mismatching targets saturate jr_miss_cnt_o at 255. Asserting rst_i during a stall cycle clears the counter, flags and count and sets pc_o=RESET_PC at the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ==== pc_sequencer : next-PC selection (branch/jump/jal/jr/stall) with a return-address stack. Rev 1.0 ====
module pc_sequencer #(
  parameter int              ADDR_W    = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           stall_i,
  input  logic                           branch_i,
  input  logic [1:0]                     branch_type_i,
  input  logic                           zero_i,
  input  logic                           neg_i,
  input  logic [ADDR_W-1:0]              imm_i,
  input  logic                           jump_i,
  input  logic                           jal_i,
  input  logic [25:0]                    target26_i,
  input  logic                           jr_i,
  input  logic [ADDR_W-1:0]              jr_target_i,
  output logic [ADDR_W-1:0]              pc_o,
  output logic [ADDR_W-1:0]              pc_plus4_o,
  output logic [ADDR_W-1:0]              link_o,
  output logic                           redirect_o,
  output logic [ADDR_W-1:0]              ras_top_o,
  output logic [$clog2(RAS_DEPTH):0]     ras_count_o,
  output logic                           ras_hit_o,
  output logic [7:0]                     jr_miss_cnt_o,
  output logic                           ras_ovf_o,
  output logic                           ras_unf_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [CNT_W-1:0]  count;
  logic [7:0]        miss_cnt;
  logic              redirect, ovf, unf;

  logic [ADDR_W-1:0] jump_target, branch_target, next_pc, top_entry;
  logic              cond_true, taken, ras_empty, ras_full, hit;
  logic              wr_en, set_ovf, set_unf;
  logic [PTR_W-1:0]  wr_ptr, next_top;
  logic [CNT_W-1:0]  next_count;

  assign pc_plus4_o    = pc + ADDR_W'(4);
  assign link_o        = pc_plus4_o;
  assign branch_target = pc_plus4_o + (imm_i << 2);

  // A 28-bit PC has no upper region bits to carry over into the jump target.
  if (ADDR_W == 28) begin : g_jt_short
    assign jump_target = {target26_i, 2'b00};
  end else begin : g_jt_full
    assign jump_target = {pc_plus4_o[ADDR_W-1:28], target26_i, 2'b00};
  end

  always_comb begin
    cond_true = 1'b0;
    case (branch_type_i)
      2'd0:    cond_true = zero_i;
      2'd1:    cond_true = !zero_i;
      2'd2:    cond_true = neg_i;
      default: cond_true = !neg_i;
    endcase
  end

  assign taken = branch_i & cond_true;

  always_comb begin
    next_pc = pc_plus4_o;
    if (stall_i)               next_pc = pc;
    else if (jr_i)             next_pc = {jr_target_i[ADDR_W-1:2], 2'b00};
    else if (jump_i || jal_i)  next_pc = jump_target;
    else if (taken)            next_pc = branch_target;
  end

  assign ras_empty   = (count == '0);
  assign ras_full    = (count == DEPTH_CNT);
  assign top_entry   = stack[top];
  assign ras_top_o   = ras_empty ? '0 : top_entry;
  assign hit         = jr_i & !stall_i & !ras_empty & (jr_target_i == top_entry);
  assign ras_hit_o   = hit;

  // jal+jr on a non-empty stack is pop-then-push: overwrite the top in place.
  always_comb begin
    wr_en      = 1'b0;
    wr_ptr     = top + PTR_W'(1);
    next_top   = top;
    next_count = count;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (!stall_i) begin
      if (jal_i && jr_i) begin
        wr_en = 1'b1;
        if (ras_empty) begin
          next_top   = top + PTR_W'(1);
          next_count = CNT_W'(1);
          set_unf    = 1'b1;
        end else begin
          wr_ptr = top;
        end
      end else if (jal_i) begin
        wr_en    = 1'b1;
        next_top = top + PTR_W'(1);
        if (ras_full) set_ovf    = 1'b1;
        else          next_count = count + CNT_W'(1);
      end else if (jr_i) begin
        if (ras_empty) begin
          set_unf = 1'b1;
        end else begin
          next_top   = top - PTR_W'(1);
          next_count = count - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc       <= RESET_PC;
      redirect <= 1'b0;
      top      <= '0;
      count    <= '0;
      miss_cnt <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      pc       <= next_pc;
      redirect <= !stall_i & (jr_i | jump_i | jal_i | taken);
      top      <= next_top;
      count    <= next_count;
      ovf      <= ovf | set_ovf;
      unf      <= unf | set_unf;
      if (!stall_i && jr_i && !hit && miss_cnt != 8'hFF)
        miss_cnt <= miss_cnt + 8'd1;
    end
  end

  // Stack storage has no reset; entries are invisible while count is zero.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i)
      stack[wr_ptr] <= link_o;
  end

  assign pc_o          = pc;
  assign redirect_o    = redirect;
  assign ras_count_o   = count;
  assign jr_miss_cnt_o = miss_cnt;
  assign ras_ovf_o     = ovf;
  assign ras_unf_o     = unf;

endmodule
`default_nettype wire
